// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmit engine. Accepts one byte per valid/ready handshake
//            and serialises it LSB-first as start bit, DATA_BITS data bits,
//            optional check bit and STOP_BITS stop bits. Bit timing comes from
//            an external baud generator that this block gates with tx_clk_en;
//            the frame advances one bit per tx_clk pulse.
// Ports    : clk            - system clock
//            rst            - synchronous reset, active-high
//            tx_en          - block enable; low forces the idle state
//            tx_clk         - baud tick, one clk wide, one per bit period
//            data_in        - byte to send (bits [DATA_BITS-1:0] used)
//            data_in_valid  - upstream has a byte on data_in
//            data_in_ready  - block can accept a byte (combinational)
//            tx             - serial line, idles high
//            tx_clk_en      - enables the baud generator
//            busy           - frame in progress
//            tx_done        - one-cycle pulse when a frame completes
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS  = 8,   // 5..8
    parameter int CHECK_MODE = 1,   // 0 none, 1 even, 2 odd, 3 fixed 0, 4 fixed 1
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       tx_clk,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       tx,
    output logic       tx_clk_en,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [7:0] c_DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] c_BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic       c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit         c_HAS_CHECK = (CHECK_MODE != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       check_q, check_d;
    logic       tx_q, tx_d;
    logic       clk_en_q, clk_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] w_data;
    logic       w_check;
    logic       w_accept;

    assign data_in_ready = tx_en && (state_q == ST_IDLE) && !rst;
    assign w_accept      = data_in_valid && data_in_ready;
    assign w_data        = data_in & c_DATA_MASK;

    // Check bit is computed from the byte as latched, so later changes on
    // data_in cannot affect it. Undefined modes fall back to a fixed 0.
    always_comb begin
        w_check = 1'b0;
        case (CHECK_MODE)
            1:       w_check = ^w_data;
            2:       w_check = ~^w_data;
            4:       w_check = 1'b1;
            default: w_check = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        check_d    = check_q;
        tx_d       = tx_q;
        clk_en_d   = clk_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    shift_d  = w_data;
                    check_d  = w_check;
                    tx_d     = 1'b0;
                    clk_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tx_clk) begin
                    // Shift right so the next bit to send is always at [0].
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_clk) begin
                    if (bit_cnt_q != c_BIT_LAST) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (c_HAS_CHECK) begin
                        tx_d    = check_q;
                        state_d = ST_CHECK;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_CHECK: begin
                if (tx_clk) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_clk) begin
                    if (stop_cnt_q != c_STOP_LAST) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        clk_en_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Disabling the block behaves exactly like reset: any frame in flight is
    // abandoned and the line returns high on the next edge.
    always_ff @(posedge clk) begin
        if (rst || !tx_en) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            check_q    <= 1'b0;
            tx_q       <= 1'b1;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            check_q    <= check_d;
            tx_q       <= tx_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx        = tx_q;
    assign tx_clk_en = clk_en_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Several instances with different
//            frame formats share clock, reset, enable, tick and data; one
//            instance at a time is exercised. A baud-tick process emulates the
//            external generator (first tick one bit period after tx_clk_en).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int NI        = 6;
    localparam int DB[NI]    = '{8, 8, 5, 6, 7, 7};
    localparam int CM[NI]    = '{1, 2, 0, 4, 6, 3};
    localparam int SB[NI]    = '{1, 1, 2, 2, 1, 2};
    localparam int c_PERIOD  = 16;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tx_en  = 1'b0;
    logic       tick   = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       valid [NI];
    logic       ready [NI];
    logic       txl   [NI];
    logic       cen   [NI];
    logic       bsy   [NI];
    logic       done  [NI];

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    bit idle_ticks = 1'b0;
    bit exp_q[$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            uart_tx #(
                .DATA_BITS (DB[g]),
                .CHECK_MODE(CM[g]),
                .STOP_BITS (SB[g])
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .tx_en        (tx_en),
                .tx_clk       (tick),
                .data_in      (din),
                .data_in_valid(valid[g]),
                .data_in_ready(ready[g]),
                .tx           (txl[g]),
                .tx_clk_en    (cen[g]),
                .busy         (bsy[g]),
                .tx_done      (done[g])
            );
        end
    endgenerate

    // Baud generator model for the selected instance.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cen[sel] === 1'b1 && !rst) begin
                cnt++;
                if (cnt == c_PERIOD) begin
                    tick = 1'b1;
                    cnt  = 0;
                end else begin
                    tick = 1'b0;
                end
            end else begin
                cnt  = 0;
                tick = idle_ticks && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Reference frame: line level of every bit period, start to last stop.
    function automatic void build_exp(input int k, input logic [7:0] d);
        int ones;
        bit c;
        ones = 0;
        c    = 1'b0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DB[k]; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (CM[k] != 0) begin
            case (CM[k])
                1:       c = (ones % 2) == 1;
                2:       c = (ones % 2) == 0;
                4:       c = 1'b1;
                default: c = 1'b0;
            endcase
            exp_q.push_back(c);
        end
        for (int i = 0; i < SB[k]; i++) exp_q.push_back(1'b1);
    endfunction

    // Presents a byte and returns at the negedge before the accepting edge.
    task automatic do_accept(input logic [7:0] d, input string name);
        bit ok;
        ok         = 1'b0;
        din        = d;
        valid[sel] = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (ready[sel] === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept timeout: ready=%b required 1", name, ready[sel]);
        end
    endtask

    // Follows one frame from its start bit to tx_done and compares the line
    // level sampled after every tick with the reference frame.
    task automatic check_frame(input logic [7:0] d, input bit keep_valid,
                               input logic [7:0] next_din, input string name);
        bit got[$];
        bit tp;
        bit seen;
        int rdy_hi;
        int bad;
        int first_bad;
        bit e;
        seen   = 1'b0;
        rdy_hi = 0;
        build_exp(sel, d);
        @(negedge clk);
        valid[sel] = keep_valid;
        din        = next_din;
        checks++;
        if (txl[sel] !== 1'b0 || cen[sel] !== 1'b1 || bsy[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s start: tx=%b cen=%b busy=%b required 0 1 1",
                     name, txl[sel], cen[sel], bsy[sel]);
        end
        tp = tick;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (tp) got.push_back(txl[sel]);
            if (done[sel] === 1'b1) seen = 1'b1;
            else if (ready[sel] !== 1'b0) rdy_hi++;
            tp = tick;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s tx_done timeout", name);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s tick count: got %0d required %0d", name, got.size(), exp_q.size());
        end
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < got.size(); i++) begin
            e = (i + 1 < exp_q.size()) ? exp_q[i + 1] : 1'b1;
            if (got[i] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bits: %0d wrong, first at tick %0d data=%h required bit %b got %b",
                     name, bad, first_bad, d,
                     (first_bad + 1 < exp_q.size()) ? exp_q[first_bad + 1] : 1'b1, got[first_bad]);
        end
        checks++;
        if (rdy_hi != 0) begin
            errors++;
            $display("FAIL %s ready during frame: %0d cycles high, required 0", name, rdy_hi);
        end
        checks++;
        if (txl[sel] !== 1'b1 || cen[sel] !== 1'b0 || bsy[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s end: tx=%b cen=%b busy=%b required 1 0 0",
                     name, txl[sel], cen[sel], bsy[sel]);
        end
    endtask

    // Idle line with stray ticks: no done pulse, line high, generator off.
    task automatic check_idle(input string name);
        int bad;
        bad        = 0;
        idle_ticks = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done[sel] !== 1'b0 || txl[sel] !== 1'b1 || cen[sel] !== 1'b0 || bsy[sel] !== 1'b0)
                bad++;
        end
        idle_ticks = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idle: %0d bad cycles, required 0 (done=%b tx=%b cen=%b busy=%b)",
                     name, bad, done[sel], txl[sel], cen[sel], bsy[sel]);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (txl[k] !== 1'b1 || cen[k] !== 1'b0 || bsy[k] !== 1'b0 ||
                done[k] !== 1'b0 || ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: tx=%b cen=%b busy=%b done=%b ready=%b required 1 0 0 0 0",
                         k, txl[k], cen[k], bsy[k], done[k], ready[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset release: ready=%b required 1", ready[0]);
        end
    endtask

    task automatic test_single(input int k, input logic [7:0] d, input string name);
        sel = k;
        do_accept(d, name);
        check_frame(d, 1'b0, 8'($urandom), name);
        check_idle(name);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        do_accept(8'h3C, "b2b_first");
        check_frame(8'h3C, 1'b1, 8'hC3, "b2b_first");
        check_frame(8'hC3, 1'b0, 8'h00, "b2b_second");
        check_idle("b2b");
    endtask

    task automatic test_reset_mid();
        int nt;
        logic [7:0] d;
        sel = 0;
        nt  = 0;
        d   = 8'($urandom);
        do_accept(d, "rst_mid");
        @(negedge clk);
        valid[sel] = 1'b0;
        for (int i = 0; i < 400 && nt < 4; i++) begin
            if (tick) nt++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txl[0] !== 1'b1 || cen[0] !== 1'b0 || bsy[0] !== 1'b0 ||
            done[0] !== 1'b0 || ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: tx=%b cen=%b busy=%b done=%b ready=%b required 1 0 0 0 0",
                     txl[0], cen[0], bsy[0], done[0], ready[0]);
        end
        rst = 1'b0;
        check_idle("rst_mid");
        test_single(0, 8'($urandom), "rst_mid_next");
    endtask

    task automatic test_enable();
        int bad;
        logic [7:0] d;
        sel = 1;
        bad = 0;
        do_accept(8'h96, "en_mid");
        @(negedge clk);
        valid[sel] = 1'b0;
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
        @(negedge clk);
        checks++;
        if (txl[1] !== 1'b1 || cen[1] !== 1'b0 || bsy[1] !== 1'b0 || ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL en_mid: tx=%b cen=%b busy=%b ready=%b required 1 0 0 0",
                     txl[1], cen[1], bsy[1], ready[1]);
        end
        d          = 8'($urandom);
        din        = d;
        valid[sel] = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (ready[1] !== 1'b0 || txl[1] !== 1'b1 || bsy[1] !== 1'b0 || done[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_idle: %0d bad cycles, required 0", bad);
        end
        tx_en = 1'b1;
        do_accept(d, "en_resume");
        check_frame(d, 1'b0, 8'($urandom), "en_resume");
        check_idle("en_resume");
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 4; n++) begin
                test_single(k, 8'($urandom), $sformatf("rand_i%0d_n%0d", k, n));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) valid[k] = 1'b0;
        test_reset();
        test_single(0, 8'h55, "default_55");
        test_single(1, 8'hA7, "odd_A7");
        test_single(2, 8'hFF, "short_FF");
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
